// File: rtl/a_sqrtb_inv_pkg.sv
// Shared widths, state encoding and error code for the a*sqrt(b) inverse block.
// Optional build macro: A_SQRTB_INV_ROUND_EN (round-half-up quotient).
package a_sqrtb_pkg;

    localparam int YW   = 12;
    localparam int AW   = 8;
    localparam int BW   = 8;
    localparam int QMAX = (1 << (BW / 2)) - 1;

    // Squarer runs BW/2 shift-add iterations; SW is its counter width.
    localparam int SW = $clog2(BW / 2);

    localparam logic [BW-1:0] B_ERR = {BW{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        CHK,
        SQR
    } state_t;

endpackage

// File: rtl/a_sqrtb_inv_restoring_div.sv
// Restoring unsigned divider, one quotient bit per clock, YW iterations per start.
// Used by a_sqrtb_inv; A_SQRTB_INV_ROUND_EN does not change this module.
module restoring_div #(
    parameter int YW = 12,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic [YW-1:0] i_y,
    input  logic [AW-1:0] i_a,
    output logic          o_done,
    output logic [YW-1:0] o_q,
    output logic [AW:0]   o_rem
);

    localparam int CW = $clog2(YW);

    logic          r_active;
    logic [CW-1:0] r_cnt;
    logic [YW-1:0] r_y;
    logic [AW-1:0] r_a;
    logic [YW-1:0] r_q;
    logic [AW:0]   r_rem;

    logic [AW:0]   w_remShift;
    logic          w_ge;
    logic [AW:0]   w_remNext;

    // The remainder stays below a, so its low AW bits hold it losslessly before the shift.
    assign w_remShift = {r_rem[AW-1:0], r_y[YW-1]};
    assign w_ge       = (w_remShift >= {1'b0, r_a});
    assign w_remNext  = w_ge ? (w_remShift - {1'b0, r_a}) : w_remShift;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_y      <= '0;
            r_a      <= '0;
            r_q      <= '0;
            r_rem    <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= CW'(YW - 1);
            r_y      <= i_y;
            r_a      <= i_a;
            r_q      <= '0;
            r_rem    <= '0;
        end else if (r_active) begin
            r_rem <= w_remNext;
            r_q   <= {r_q[YW-2:0], w_ge};
            r_y   <= {r_y[YW-2:0], 1'b0};
            if (r_cnt == '0) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // High during the final iteration, so the caller can leave its DIV state on that edge.
    assign o_done = r_active && (r_cnt == '0);
    assign o_q    = r_q;
    assign o_rem  = r_rem;

endmodule

// File: rtl/a_sqrtb_inv.sv
// Recovers b = (y / a)^2: restoring divide, range check, then shift-add square.
// Optional build macro: A_SQRTB_INV_ROUND_EN rounds the quotient half-up before the range check.
module a_sqrtb_inv
    import a_sqrtb_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [YW-1:0] y_in,
    input  logic [AW-1:0] a_in,
    input  logic          in_ready,
    output logic          busy,
    output logic [BW-1:0] b_out,
    output logic          err,
    output logic          y_ready
);

    localparam int HW = BW / 2;
    localparam logic [SW-1:0] SQR_LAST = SW'(HW - 1);

    state_t r_state;
    state_t w_stateNext;

    logic [BW-1:0] r_mcand;
    logic [HW-1:0] r_mplier;
    logic [BW-1:0] r_acc;
    logic [SW-1:0] r_sqrCnt;

    logic          w_accept;
    logic          w_divStart;
    logic          w_divDone;
    logic [YW-1:0] w_q;
    logic [YW:0]   w_qFinal;
    logic          w_overflow;
    logic [BW-1:0] w_accNext;

    assign w_accept   = (r_state == IDLE) && in_ready;
    assign w_divStart = w_accept && (a_in != '0);

`ifdef A_SQRTB_INV_ROUND_EN
    logic [AW:0]   w_rem;
    logic [AW-1:0] r_a;
    logic          w_roundUp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a <= '0;
        end else if (w_accept) begin
            r_a <= a_in;
        end
    end

    assign w_roundUp = ({w_rem, 1'b0} >= {2'b00, r_a});
    assign w_qFinal  = {1'b0, w_q} + (YW + 1)'(w_roundUp);
`else
    logic [AW:0] w_remUnused;

    assign w_qFinal = {1'b0, w_q};
`endif

    restoring_div #(
        .YW (YW),
        .AW (AW)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_divStart),
        .i_y     (y_in),
        .i_a     (a_in),
        .o_done  (w_divDone),
        .o_q     (w_q),
`ifdef A_SQRTB_INV_ROUND_EN
        .o_rem   (w_rem)
`else
        .o_rem   (w_remUnused)
`endif
    );

    assign w_overflow = (w_qFinal > (YW + 1)'(QMAX));
    assign w_accNext  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign busy       = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: if (w_divStart) w_stateNext = DIV;
            DIV:  if (w_divDone) w_stateNext = CHK;
            CHK:  w_stateNext = w_overflow ? IDLE : SQR;
            SQR:  if (r_sqrCnt == SQR_LAST) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Results are registered and held in IDLE; a divide-by-zero resolves on the accepting edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_out    <= '0;
            err      <= 1'b0;
            y_ready  <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_sqrCnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_ready) begin
                        y_ready <= 1'b0;
                        err     <= 1'b0;
                        if (a_in == '0) begin
                            err     <= 1'b1;
                            b_out   <= B_ERR;
                            y_ready <= 1'b1;
                        end
                    end
                end
                CHK: begin
                    if (w_overflow) begin
                        err     <= 1'b1;
                        b_out   <= B_ERR;
                        y_ready <= 1'b1;
                    end else begin
                        r_mcand  <= {{(BW - HW){1'b0}}, w_qFinal[HW-1:0]};
                        r_mplier <= w_qFinal[HW-1:0];
                        r_acc    <= '0;
                        r_sqrCnt <= '0;
                    end
                end
                SQR: begin
                    r_acc    <= w_accNext;
                    r_mcand  <= {r_mcand[BW-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[HW-1:1]};
                    r_sqrCnt <= r_sqrCnt + 1'b1;
                    if (r_sqrCnt == SQR_LAST) begin
                        b_out   <= w_accNext;
                        err     <= 1'b0;
                        y_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
